// File: rtl/pcie_regs_responder_if.sv
// Request/completion bus between the PCIe RX/TX request adapter and the register responder.
// Latency: none, wires only.
// Backpressure: valid/ready on the request side (rx*) and on the completion side (cpl*).
interface pcie_regs_responder_if;
    logic        rxValid_in;
    logic        rxReady_out;
    logic        rxWrite_in;
    logic [5:0]  rxAddr_in;
    logic [3:0]  rxByteEn_in;
    logic [31:0] rxData_in;
    logic [7:0]  rxTag_in;
    logic        cplValid_out;
    logic        cplReady_in;
    logic [31:0] cplData_out;
    logic [7:0]  cplTag_out;

    // Responder side
    modport slave (
        input  rxValid_in, rxWrite_in, rxAddr_in, rxByteEn_in, rxData_in, rxTag_in, cplReady_in,
        output rxReady_out, cplValid_out, cplData_out, cplTag_out
    );

    // Requester side
    modport master (
        output rxValid_in, rxWrite_in, rxAddr_in, rxByteEn_in, rxData_in, rxTag_in, cplReady_in,
        input  rxReady_out, cplValid_out, cplData_out, cplTag_out
    );
endinterface

// File: rtl/pcie_regs_responder.sv
// BAR dword register file: reg0 magic, reg1 access counters (PCIE_REGS_ACCESS_COUNT_EN), reg2..7 r/w.
// Latency: read completion valid the cycle after accept when the completion buffer is empty.
// Backpressure: 2-entry in-order completion buffer; rxReady_out (registered) drops while it is full.
module pcie_regs_responder #(
    parameter logic [63:0] MAGIC = 64'hCAFEF00D_00010001
) (
    input  logic                     clk_in,
    input  logic                     reset_in,
    pcie_regs_responder_if.slave     bus
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_rx_rdy;

    logic [31:0] r_fifo_dat [2];
    logic [7:0]  r_fifo_tag [2];
    logic        r_wr_ptr;
    logic        r_rd_ptr;

    logic [63:0] r_regs [6];

    logic        w_acc;
    logic        w_push;
    logic        w_pop;
    logic        w_wr_acc;
    logic        w_cpl_vld;
    logic [2:0]  w_idx;
    logic [2:0]  w_ri;
    logic        w_hi;
    logic [63:0] w_rd_qword;
    logic [31:0] w_rd_dword;

`ifdef PCIE_REGS_ACCESS_COUNT_EN
    logic [31:0] r_wr_cnt;
    logic [31:0] r_rd_cnt;
`endif

    // Address bits [1:0] are not decoded; offsets alias every 64 bytes.
    assign w_idx     = bus.rxAddr_in[5:3];
    assign w_hi      = bus.rxAddr_in[2];
    assign w_ri      = w_idx - 3'd2;

    assign w_cpl_vld = (r_state != ST_EMPTY);
    assign w_acc     = bus.rxValid_in && r_rx_rdy;
    assign w_push    = w_acc && !bus.rxWrite_in;
    assign w_wr_acc  = w_acc && bus.rxWrite_in;
    assign w_pop     = w_cpl_vld && bus.cplReady_in;

    assign bus.rxReady_out  = r_rx_rdy;
    assign bus.cplValid_out = w_cpl_vld;
    assign bus.cplData_out  = r_fifo_dat[r_rd_ptr];
    assign bus.cplTag_out   = r_fifo_tag[r_rd_ptr];

    // Read mux: register state as it stands before this cycle's accept edge
    always_comb begin
        w_rd_qword = '0;
        case (w_idx)
            3'd0: w_rd_qword = MAGIC;
`ifdef PCIE_REGS_ACCESS_COUNT_EN
            3'd1: w_rd_qword = {r_wr_cnt, r_rd_cnt};
`else
            3'd1: w_rd_qword = '0;
`endif
            default: w_rd_qword = r_regs[w_ri];
        endcase
        w_rd_dword = w_hi ? w_rd_qword[63:32] : w_rd_qword[31:0];
    end

    // Occupancy state register; ready follows the next-state count so FULL blocks the following cycle
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            r_state  <= ST_EMPTY;
            r_rx_rdy <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_rx_rdy <= (w_state_nxt != ST_FULL);
        end
    end

    // Occupancy next state; push+pop together only happens from ONE since FULL refuses requests
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_EMPTY: if (w_push) w_state_nxt = ST_ONE;
            ST_ONE: begin
                if (w_push && !w_pop)      w_state_nxt = ST_FULL;
                else if (w_pop && !w_push) w_state_nxt = ST_EMPTY;
            end
            ST_FULL:  if (w_pop) w_state_nxt = ST_ONE;
            default:  w_state_nxt = ST_EMPTY;
        endcase
    end

    // Completion storage: write at tail on read accept, advance head on consume
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                r_fifo_dat[i] <= '0;
                r_fifo_tag[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_fifo_dat[r_wr_ptr] <= w_rd_dword;
                r_fifo_tag[r_wr_ptr] <= bus.rxTag_in;
                r_wr_ptr             <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
        end
    end

    // Byte-enabled writes into reg2..reg7; writes to reg0/reg1 are dropped
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            for (int i = 0; i < 6; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_acc && (w_idx >= 3'd2)) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.rxByteEn_in[b]) begin
                    r_regs[w_ri][{w_hi, b[1:0], 3'b000} +: 8] <= bus.rxData_in[b*8 +: 8];
                end
            end
        end
    end

`ifdef PCIE_REGS_ACCESS_COUNT_EN
    // Accepted-request counters, free-running and wrapping at 2^32
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            r_wr_cnt <= '0;
            r_rd_cnt <= '0;
        end else begin
            if (w_wr_acc) r_wr_cnt <= r_wr_cnt + 32'd1;
            if (w_push)   r_rd_cnt <= r_rd_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pcie_regs_responder.sv
// Directed bench for pcie_regs_responder with an in-order completion scoreboard.
// Latency: read completions expected in accept order; head-of-line held while stalled.
// Backpressure: cplReady_in toggled by the stimulus to exercise the full buffer.
module tb_pcie_regs_responder;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    logic [39:0] sb [$];

    pcie_regs_responder_if bus ();

    pcie_regs_responder dut (
        .clk_in   (clk),
        .reset_in (rst),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    // Completion monitor: a handshake seen at the falling edge completes at the next rising edge
    always @(negedge clk) begin
        if (!rst && bus.cplValid_out === 1'b1 && bus.cplReady_in === 1'b1) begin
            chk("cpl_expected", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                logic [39:0] e;
                e = sb.pop_front();
                chk("cpl_tag",  64'(bus.cplTag_out),  64'(e[39:32]));
                chk("cpl_data", 64'(bus.cplData_out), 64'(e[31:0]));
            end
        end
    end

    // Called at rising edge + 1; returns at rising edge + 1 after the accept edge, valid left high
    task automatic do_req(input bit wr, input logic [5:0] addr, input logic [3:0] be,
                          input logic [31:0] dat, input logic [7:0] tag, input logic [31:0] exp);
        bit done;
        done = 1'b0;
        bus.rxValid_in  = 1'b1;
        bus.rxWrite_in  = wr;
        bus.rxAddr_in   = addr;
        bus.rxByteEn_in = be;
        bus.rxData_in   = dat;
        bus.rxTag_in    = tag;
        for (int i = 0; i < 64 && !done; i++) begin
            @(negedge clk);
            if (bus.rxReady_out === 1'b1) begin
                @(posedge clk);
                if (!wr) sb.push_back({tag, exp});
                done = 1'b1;
                #1;
            end else begin
                @(posedge clk);
                #1;
            end
        end
        chk("req_accept_timeout", 64'(done), 64'd1);
    endtask

    task automatic wr_req(input logic [5:0] addr, input logic [3:0] be, input logic [31:0] dat);
        do_req(1'b1, addr, be, dat, 8'h00, 32'h0);
    endtask

    task automatic rd_req(input logic [5:0] addr, input logic [7:0] tag, input logic [31:0] exp);
        do_req(1'b0, addr, 4'h0, 32'h0, tag, exp);
    endtask

    task automatic idle();
        bus.rxValid_in = 1'b0;
    endtask

    task automatic drain();
        idle();
        for (int i = 0; i < 200 && sb.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        chk("drain_remaining", 64'(sb.size()), 64'd0);
        @(negedge clk);
        chk("no_extra_cpl", 64'(bus.cplValid_out), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] exp_wcnt;
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        bus.rxValid_in  = 1'b0;
        bus.rxWrite_in  = 1'b0;
        bus.rxAddr_in   = '0;
        bus.rxByteEn_in = '0;
        bus.rxData_in   = '0;
        bus.rxTag_in    = '0;
        bus.cplReady_in = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rdy",      64'(bus.rxReady_out),  64'd0);
        chk("rst_cpl_vld",  64'(bus.cplValid_out), 64'd0);
        chk("rst_cpl_data", 64'(bus.cplData_out),  64'd0);
        chk("rst_cpl_tag",  64'(bus.cplTag_out),   64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rdy_after_rst", 64'(bus.rxReady_out), 64'd1);

        // Six dword writes, then access counters before any read is counted
        wr_req(6'h14, 4'hF, 32'h34D9E13F);
        wr_req(6'h1C, 4'hF, 32'h863FFC01);
        wr_req(6'h24, 4'hF, 32'h4954F539);
        wr_req(6'h2C, 4'hF, 32'h28B3C29E);
        wr_req(6'h34, 4'hF, 32'h1B6B3B92);
        wr_req(6'h3C, 4'hF, 32'h92033EB1);
`ifdef PCIE_REGS_ACCESS_COUNT_EN
        exp_wcnt = 32'd6;
`else
        exp_wcnt = 32'd0;
`endif
        rd_req(6'h08, 8'h10, 32'h00000000);
        rd_req(6'h0C, 8'h11, exp_wcnt);
        drain();

        // Six dword readback, back to back
        rd_req(6'h14, 8'h20, 32'h34D9E13F);
        rd_req(6'h1C, 8'h21, 32'h863FFC01);
        rd_req(6'h24, 8'h22, 32'h4954F539);
        rd_req(6'h2C, 8'h23, 32'h28B3C29E);
        rd_req(6'h34, 8'h24, 32'h1B6B3B92);
        rd_req(6'h3C, 8'h25, 32'h92033EB1);
        drain();

        // Magic and read-only reg0
        rd_req(6'h00, 8'h40, 32'h00010001);
        rd_req(6'h04, 8'h41, 32'hCAFEF00D);
        wr_req(6'h00, 4'hF, 32'hFFFFFFFF);
        rd_req(6'h00, 8'h42, 32'h00010001);
        drain();

        // Byte enables
        wr_req(6'h10, 4'b1111, 32'hAABBCCDD);
        wr_req(6'h10, 4'b0101, 32'h11223344);
        rd_req(6'h10, 8'h50, 32'hAA22CC44);
        drain();

        // Back-pressure: two accepts fill the buffer, ready drops, head holds
        bus.cplReady_in = 1'b0;
        rd_req(6'h14, 8'h05, 32'h34D9E13F);
        rd_req(6'h1C, 8'h06, 32'h863FFC01);
        idle();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_rdy_low",  64'(bus.rxReady_out),  64'd0);
            chk("bp_vld",      64'(bus.cplValid_out), 64'd1);
            chk("bp_hold_tag", 64'(bus.cplTag_out),   64'h05);
            chk("bp_hold_dat", 64'(bus.cplData_out),  64'h34D9E13F);
        end
        @(posedge clk);
        #1;
        bus.cplReady_in = 1'b1;
        rd_req(6'h24, 8'h07, 32'h4954F539);
        drain();

        // Reset mid-operation with two reads pending
        bus.cplReady_in = 1'b0;
        rd_req(6'h14, 8'h08, 32'h34D9E13F);
        rd_req(6'h18, 8'h09, 32'h0);
        idle();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        @(negedge clk);
        chk("midrst_cpl_vld", 64'(bus.cplValid_out), 64'd0);
        @(posedge clk);
        #1;
        bus.cplReady_in = 1'b1;
        rd_req(6'h10, 8'h30, 32'h00000000);
        chk("midrst_lat_vld", 64'(bus.cplValid_out), 64'd1);
        chk("midrst_lat_tag", 64'(bus.cplTag_out),   64'h30);
        rd_req(6'h14, 8'h31, 32'h00000000);
        rd_req(6'h0C, 8'h32, 32'h00000000);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pcie_regs_responder.md
# pcie_regs_responder

Endpoint-side register file that services BAR0/BAR1 dword memory reads and writes issued by the root-port BFM driver and by host software. It sits between the PCIe application RX/TX request adapter and the user logic. It decodes accepted requests into eight 64-bit registers and returns read completions in order through a 2-entry completion buffer.

## Interface
- `MAGIC`, default `64'hCAFEF00D_00010001`: read-only value of register 0.
- `clk_in` in 1: PCIe application clock.
- `reset_in` in 1: synchronous, active-high reset.
- `rxValid_in` in 1: request valid.
- `rxReady_out` out 1: request accepted when `rxValid_in && rxReady_out` at a rising edge.
- `rxWrite_in` in 1: 1 = memory write, 0 = memory read.
- `rxAddr_in` in 6: byte offset within the BAR.
  - Bits [5:3] are the register index; bit [2] is the dword select (0 = low, 1 = high).
  - Bits [1:0] are ignored.
  - Higher BAR address bits are not presented, so accesses alias every 64 bytes.
- `rxByteEn_in` in 4: write byte enables; ignored for reads.
- `rxData_in` in 32: write data.
- `rxTag_in` in 8: request tag, returned with the completion.
- `cplValid_out` out 1: completion valid.
- `cplReady_in` in 1: completion consumed when `cplValid_out && cplReady_in` at a rising edge.
- `cplData_out` out 32: read data.
- `cplTag_out` out 8: tag of the originating read.

## Operation
- Register map (64-bit registers, dword-accessible):
  - reg0: `MAGIC`, read-only; writes are dropped.
  - reg1: access counters, read-only; see Configuration.
  - reg2..reg7: read/write, reset value 0.
- Write, accepted:
  - For each `rxByteEn_in[i]` = 1, byte i of the addressed dword takes `rxData_in[8i+7:8i]`.
  - No completion is generated.
- Read, accepted:
  - The addressed dword is sampled in the accept cycle, giving register state before any later request.
  - `{dword, tag}` is pushed into the completion FIFO.
- Completion FIFO:
  - 2 entries, in order.
  - `count` is 0..2; the head drives `cplData_out`/`cplTag_out`.
- `rxReady_out = (count < 2)`, registered. It applies to writes as well, so that request ordering is preserved.
- State is the FIFO occupancy: EMPTY (0), ONE (1), FULL (2).
  - Push only: count+1.
  - Pop only: count−1.
  - Push and pop in the same cycle: count unchanged; reachable only from ONE.
  - FULL: `rxReady_out` is 0, so no push is possible.
- `cplData_out`/`cplTag_out` hold their value while `cplValid_out && !cplReady_in`.

## Timing
- Reset values:
  - `rxReady_out` = 0 during reset and 1 in the first cycle after reset deasserts.
  - `cplValid_out` = 0, `cplData_out` = 0, `cplTag_out` = 0.
  - FIFO count = 0; reg2..reg7 = 0; counters = 0.
- Read latency:
  - Read accepted at edge N → `cplValid_out` = 1 after edge N (visible in cycle N+1) when the FIFO was EMPTY.
  - Otherwise the completion appears after the earlier entries pop.
- Write visibility: a write accepted at edge N is returned by a read accepted at edge N+1.
- Back-to-back requests: accepted every cycle while `count < 2`. With `cplReady_in` held 1, sustained throughput is one read per cycle.
- `rxReady_out` is updated from the next-state count, so a FULL FIFO deasserts ready in the cycle after the second push.
- Reset asserted mid-operation: FIFO contents are discarded, registers are cleared, and no completion is emitted for in-flight reads.

## Configuration
- `PCIE_REGS_ACCESS_COUNT_EN` defined:
  - reg1 high dword = count of accepted writes; reg1 low dword = count of accepted reads.
  - Both counters are 32-bit, wrap at 2^32 to 0, and are incremented at the accept edge.
  - A read of reg1 returns the count before that read is counted.
- Macro undefined: reg1 reads 0 and no counter flops are synthesized.

## Test plan
- Six-dword check:
  - Write `34D9E13F`, `863FFC01`, `4954F539`, `28B3C29E`, `1B6B3B92`, `92033EB1` to offsets 0x14, 0x1C, 0x24, 0x2C, 0x34, 0x3C.
  - Read each offset back → completions in tag order return those exact values.
- Magic and read-only: read 0x00 and 0x04 → `00010001`, `CAFEF00D`. Write `FFFFFFFF` to 0x00, then read 0x00 → `00010001`.
- Byte enables: write `AABBCCDD` with BE=`1111` to 0x10, then `11223344` with BE=`0101` to 0x10. Read 0x10 → `AA22CC44`.
- Back-pressure:
  - Hold `cplReady_in`=0 and issue 3 reads with tags 5, 6, 7 → `rxReady_out` drops after the second accept.
  - Release `cplReady_in` → tags 5, 6, 7 are returned in order with data stable while stalled.
- Counters (macro on):
  - 6 writes then 1 read of 0x08 → `00000000`.
  - A following read of 0x0C → `00000006`.
  - Macro off: reg1 reads 0.
- Reset mid-operation:
  - Two reads pending and `cplReady_in`=0; pulse `reset_in` for one cycle → `cplValid_out`=0 and reg2 reads 0.
  - The next read returns normally one cycle after accept.
